blctrl_target: RTL and testbench

I2C target that emulates a bank of eight BL-Ctrl ESCs at consecutive 7-bit addresses and converts received speed writes into a packed 8×8-bit speed array for the DShot output stage. It is the bus-side counterpart of the BL-Ctrl master handler: a flight controller writes single speed bytes here and the block presents them to the converter. A per-motor watchdog zeroes a motor's speed when its updates stop arriving.

---
 rtl/blctrl_target_pkg.sv | 15 +
 rtl/blctrl_target_i2c_line_sync.sv | 22 ++
 rtl/blctrl_target.sv | 131 +++++++++++++
 tb/tb_blctrl_target.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/blctrl_target_pkg.sv
// Shared BL-Ctrl constants and the I2C target state encoding.
// The master handler uses the same base address.
package blctrl_target_pkg;
  localparam int         BLCTRL_NUM_MOTORS   = 8;
  localparam logic [6:0] BLCTRL_BASE_ADDRESS = 7'h29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_t;
endpackage

// File: rtl/blctrl_target_i2c_line_sync.sv
// Two-flop synchronizer plus edge register for one open-drain line.
// Level is 2 clk behind the pin; rise/fall are valid combinationally with it; no backpressure.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;

  // Reset to the idle-high bus level so no edge is seen on release.
  always_ff @(posedge clk) begin
    if (rst) sr <= 3'b111;
    else     sr <= {sr[1:0], din};
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];
endmodule

// File: rtl/blctrl_target.sv
// I2C target emulating eight BL-Ctrl ESCs; one written speed byte per transfer, per-motor watchdog.
// Bus events act 3 clk after the pin edge, commit lands 1 clk later; SCL is never stretched.
module blctrl_target
  import blctrl_target_pkg::*;
#(
  parameter logic [6:0]  BASE_ADDRESS   = BLCTRL_BASE_ADDRESS,
  parameter int unsigned TIMEOUT_CYCLES = 1600000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  output logic [63:0] targetSpeedFlat,
  output logic        speedUpdate,
  output logic [2:0]  updateIndex,
  output logic [7:0]  motorAlive
);
  localparam int WD_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start_evt, stop_evt, commit;
  logic [7:0] addr_off;

  state_t     state;
  logic [7:0] shreg;
  logic [3:0] bit_cnt;
  logic [2:0] index;

  logic [BLCTRL_NUM_MOTORS-1:0][7:0]      speed;
  logic [BLCTRL_NUM_MOTORS-1:0][WD_W-1:0] wd_cnt;
  logic [BLCTRL_NUM_MOTORS-1:0]           alive;

  i2c_line_sync u_scl_sync (.clk(clk), .rst(rst), .din(scl_i),
                            .level(scl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_sync u_sda_sync (.clk(clk), .rst(rst), .din(sda_i),
                            .level(sda), .rise(sda_rise), .fall(sda_fall));

  assign start_evt = scl & sda_fall;
  assign stop_evt  = scl & sda_rise;
  // Widened so addresses below the base go negative and fall outside 0..7.
  assign addr_off  = {1'b0, shreg[7:1]} - {1'b0, BASE_ADDRESS};
  assign commit    = (state == ST_DATA) && scl_fall && (bit_cnt == 4'd8);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sda_t   <= 1'b1;
      shreg   <= '0;
      bit_cnt <= '0;
      index   <= '0;
    end else if (start_evt) begin
      state   <= ST_ADDR;
      bit_cnt <= '0;
      sda_t   <= 1'b1;
    end else if (stop_evt) begin
      state   <= ST_IDLE;
      sda_t   <= 1'b1;
    end else begin
      if (scl_rise && (state == ST_ADDR || state == ST_DATA) && bit_cnt != 4'd8) begin
        shreg   <= {shreg[6:0], sda};
        bit_cnt <= bit_cnt + 4'd1;
      end
      case (state)
        ST_ADDR: if (scl_fall && bit_cnt == 4'd8) begin
          bit_cnt <= '0;
          if (addr_off < 8'd8 && !shreg[0]) begin
            index <= addr_off[2:0];
            sda_t <= 1'b0;
            state <= ST_ADDR_ACK;
          end else begin
            state <= ST_IGNORE;
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          sda_t <= 1'b1;
          state <= ST_DATA;
        end
        ST_DATA: if (commit) begin
          bit_cnt <= '0;
          sda_t   <= 1'b0;
          state   <= ST_DATA_ACK;
        end
        // Only one byte per transfer is taken; the rest are NACKed.
        ST_DATA_ACK: if (scl_fall) begin
          sda_t <= 1'b1;
          state <= ST_IGNORE;
        end
        default: ;
      endcase
    end
  end

  // A commit outranks expiry in the same cycle: new speed stored, counter reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed       <= '0;
      wd_cnt      <= '0;
      alive       <= '0;
      speedUpdate <= 1'b0;
      updateIndex <= '0;
    end else begin
      speedUpdate <= commit;
      if (commit) updateIndex <= index;
      for (int n = 0; n < BLCTRL_NUM_MOTORS; n++) begin
        if (commit && index == 3'(n)) begin
          speed[n]  <= shreg;
          alive[n]  <= 1'b1;
          wd_cnt[n] <= WD_W'(TIMEOUT_CYCLES);
        end else if (TIMEOUT_CYCLES != 0 && wd_cnt[n] != '0) begin
          wd_cnt[n] <= wd_cnt[n] - 1'b1;
          if (wd_cnt[n] == WD_W'(1)) begin
            speed[n] <= '0;
            alive[n] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    targetSpeedFlat = '0;
    for (int n = 0; n < BLCTRL_NUM_MOTORS; n++)
      targetSpeedFlat[8*(BLCTRL_NUM_MOTORS-1-n) +: 8] = speed[n];
  end

  assign motorAlive = alive;
  assign sda_o      = 1'b0;
endmodule

// File: tb/tb_blctrl_target.sv
// Bench for blctrl_target: bit-banged I2C master against a motor-array model.
// Two instances share the bus: watchdog disabled, and a 100-cycle watchdog.
module tb_blctrl_target;
  localparam int Q          = 4;
  localparam int WD_TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_line;

  logic        sda_o, sda_t, speedUpdate;
  logic [63:0] targetSpeedFlat;
  logic [2:0]  updateIndex;
  logic [7:0]  motorAlive;
  logic        wd_sda_o, wd_sda_t, wd_upd;
  logic [63:0] wd_flat;
  logic [2:0]  wd_idx;
  logic [7:0]  wd_alive;

  always #5 clk = ~clk;

  assign sda_line = sda_m & (sda_t ? 1'b1 : sda_o) & (wd_sda_t ? 1'b1 : wd_sda_o);

  blctrl_target #(.BASE_ADDRESS(7'h29), .TIMEOUT_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_o(sda_o), .sda_t(sda_t),
    .targetSpeedFlat(targetSpeedFlat), .speedUpdate(speedUpdate),
    .updateIndex(updateIndex), .motorAlive(motorAlive));

  blctrl_target #(.BASE_ADDRESS(7'h29), .TIMEOUT_CYCLES(WD_TIMEOUT)) dut_wd (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_o(wd_sda_o), .sda_t(wd_sda_t),
    .targetSpeedFlat(wd_flat), .speedUpdate(wd_upd),
    .updateIndex(wd_idx), .motorAlive(wd_alive));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int upd_cnt = 0;
  int low_cnt = 0;
  int wd_commit_cyc = 0;
  bit wd_seen = 1'b0;
  logic [2:0] last_idx = '0;
  logic [7:0] ref_speed [8];
  logic [7:0] ref_alive;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (speedUpdate) begin
      upd_cnt++;
      last_idx = updateIndex;
    end
    if (!sda_t) low_cnt++;
    if (wd_upd && wd_idx == 3'd3) begin
      wd_commit_cyc = cyc;
      wd_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_flat();
    logic [63:0] f = '0;
    for (int n = 0; n < 8; n++) f = {f[55:0], ref_speed[n]};
    return f;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 8; n++) ref_speed[n] = 8'h00;
    ref_alive = 8'h00;
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait(); scl = 1'b1; qwait(); sda_m = 1'b0; qwait(); scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait(); scl = 1'b1; qwait(); sda_m = 1'b1; qwait();
  endtask

  task automatic i2c_bit(input logic b, output logic rd);
    sda_m = b; qwait(); scl = 1'b1; qwait(); rd = sda_line; qwait(); scl = 1'b0; qwait();
  endtask

  task automatic i2c_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  // One transfer: address then nb data bytes; only the first byte to a motor address is taken.
  task automatic xfer(input logic [6:0] a, input logic rw, input int nb,
                      input logic [7:0] d0, input logic [7:0] d1);
    logic ack;
    int   u0, l0, m;
    bit   ok;
    m  = int'(a) - 'h29;
    ok = (m >= 0) && (m <= 7) && !rw;
    u0 = upd_cnt;
    l0 = low_cnt;
    i2c_start();
    i2c_byte({a, rw}, ack);
    check("addr_ack", ack, ok);
    if (ack) begin
      for (int i = 0; i < nb; i++) begin
        i2c_byte((i == 0) ? d0 : d1, ack);
        check("data_ack", ack, i == 0);
      end
    end
    i2c_stop();
    if (ok) begin
      ref_speed[m] = d0;
      ref_alive[m] = 1'b1;
      check("upd_idx", last_idx, m);
    end else begin
      check("sda_released", low_cnt - l0, 0);
    end
    check("strobes", upd_cnt - u0, ok);
    check("speeds", targetSpeedFlat, exp_flat());
    check("alive", motorAlive, ref_alive);
  endtask

  initial begin
    logic ack, r;
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_sda_t", sda_t, 1'b1);
    check("rst_sda_o", sda_o, 1'b0);
    check("rst_flat", targetSpeedFlat, 64'h0);
    check("rst_upd", speedUpdate, 1'b0);
    check("rst_idx", updateIndex, 3'd0);
    check("rst_alive", motorAlive, 8'h00);
    check("rst_wd_alive", wd_alive, 8'h00);
    rst = 1'b0;
    qwait();

    xfer(7'h29, 1'b0, 1, 8'h80, 8'h00);
    check("m0_speed", targetSpeedFlat[63:56], 8'h80);
    check("m0_alive", motorAlive, 8'h01);

    for (int n = 0; n < 8; n++) xfer(7'(8'h29 + n), 1'b0, 1, 8'(8'h10 + n), 8'h00);
    check("seq_flat", targetSpeedFlat, 64'h1011121314151617);

    xfer(7'h28, 1'b0, 1, 8'hEE, 8'h00);
    xfer(7'h31, 1'b0, 1, 8'hEE, 8'h00);
    xfer(7'h2A, 1'b1, 1, 8'hEE, 8'h00);
    check("nack_flat", targetSpeedFlat, 64'h1011121314151617);

    xfer(7'h29, 1'b0, 2, 8'h40, 8'h50);
    check("two_byte", targetSpeedFlat[63:56], 8'h40);

    // Repeated start between two writes.
    i2c_start();
    i2c_byte({7'h2C, 1'b0}, ack); check("rs_addr0", ack, 1'b1);
    i2c_byte(8'h77, ack);         check("rs_data0", ack, 1'b1);
    i2c_start();
    i2c_byte({7'h2D, 1'b0}, ack); check("rs_addr1", ack, 1'b1);
    i2c_byte(8'h88, ack);         check("rs_data1", ack, 1'b1);
    i2c_stop();
    ref_speed[3] = 8'h77;
    ref_speed[4] = 8'h88;
    check("rs_flat", targetSpeedFlat, exp_flat());

    for (int t = 0; t < 16; t++) begin
      xfer(7'($urandom_range(32'h27, 32'h32)), 1'($urandom_range(0, 5) == 0),
           int'($urandom_range(1, 2)), 8'($urandom), 8'($urandom));
    end

    // Watchdog: speed survives TIMEOUT-1 cycles after commit, zeroed at TIMEOUT.
    wd_seen = 1'b0;
    xfer(7'h2C, 1'b0, 1, 8'h55, 8'h00);
    check("wd_commit_seen", wd_seen, 1'b1);
    while (wd_seen && cyc < wd_commit_cyc + WD_TIMEOUT - 1) @(negedge clk);
    check("wd_speed_live", wd_flat[39:32], 8'h55);
    check("wd_alive_live", wd_alive[3], 1'b1);
    @(negedge clk);
    check("wd_speed_expired", wd_flat[39:32], 8'h00);
    check("wd_alive_expired", wd_alive[3], 1'b0);
    check("nowd_alive_kept", motorAlive[3], 1'b1);

    // Reset while the target is driving the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(i == 0 ? 1'b0 : 1'(7'h2E >> (i - 1)), r);
    sda_m = 1'b1; qwait(); scl = 1'b1; qwait();
    check("ack_driven", sda_t, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ack_release", sda_t, 1'b1);
    rst = 1'b0;
    scl = 1'b0; qwait();
    i2c_stop();
    model_reset();
    check("rst_ack_flat", targetSpeedFlat, 64'h0);
    check("rst_ack_alive", motorAlive, 8'h00);

    // Reset during bit 5 of a data byte.
    xfer(7'h2E, 1'b0, 1, 8'h99, 8'h00);
    i2c_start();
    i2c_byte({7'h2F, 1'b0}, ack); check("rst5_addr_ack", ack, 1'b1);
    for (int i = 7; i >= 4; i--) i2c_bit(1'(8'hC3 >> i), r);
    sda_m = 1'b0; qwait(); scl = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst5_sda_t", sda_t, 1'b1);
    check("rst5_flat", targetSpeedFlat, 64'h0);
    check("rst5_alive", motorAlive, 8'h00);
    rst = 1'b0;
    qwait(); scl = 1'b0; qwait();
    i2c_stop();
    model_reset();
    xfer(7'h2F, 1'b0, 1, 8'hA5, 8'h00);
    check("post_rst_m6", targetSpeedFlat[15:8], 8'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
